// File: rtl/bus_pkg.sv
// Shared bus constants: active-low enable levels, read/write encoding,
// default widths and the master-interface FSM state encoding.
package bus_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } bm_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Per-master bus interface: turns a one-cycle CPU access strobe into a
// request/grant/strobe/ready bus transaction and returns read data.
module bus_master_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              busy,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  bm_state_e         r_state;
  bm_state_e         w_state_next;
  logic              r_bus_req_;
  logic              r_bus_as_;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_rw;
  logic [DATA_W-1:0] r_bus_wr_data;
  logic [DATA_W-1:0] r_rd_buf;
  logic              w_done;

  // Ready is only honoured once the strobe has been seen low for its cycle,
  // so the earliest completion is the cycle after the strobe.
  assign w_done = (r_state == ACCESS) && (bus_rdy_ == ENABLE_) && (r_bus_as_ == DISABLE_);

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    cpu_rd_data  = '0;
    case (r_state)
      IDLE: begin
        if ((cpu_as_ == ENABLE_) && !flush) begin
          w_state_next = REQ;
          busy         = 1'b1;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus_grnt_ == ENABLE_) w_state_next = ACCESS;
      end
      ACCESS: begin
        if (w_done) begin
          cpu_rd_data  = bus_rd_data;
          w_state_next = stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      STALL: begin
        cpu_rd_data = r_rd_buf;
        if (!stall) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bus_req_    <= DISABLE_;
      r_bus_as_     <= DISABLE_;
      r_bus_addr    <= '0;
      r_bus_rw      <= READ;
      r_bus_wr_data <= '0;
      r_rd_buf      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_state_next == REQ) begin
            r_bus_req_    <= ENABLE_;
            r_bus_addr    <= cpu_addr;
            r_bus_rw      <= cpu_rw;
            r_bus_wr_data <= cpu_wr_data;
          end
        end
        REQ: begin
          if (bus_grnt_ == ENABLE_) r_bus_as_ <= ENABLE_;
        end
        ACCESS: begin
          r_bus_as_ <= DISABLE_;
          if (w_done) begin
            r_rd_buf      <= bus_rd_data;
            r_bus_req_    <= DISABLE_;
            r_bus_addr    <= '0;
            r_bus_rw      <= READ;
            r_bus_wr_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_addr    = r_bus_addr;
  assign bus_rw      = r_bus_rw;
  assign bus_wr_data = r_bus_wr_data;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: scenario tasks drive a cycle-exact
// bus handshake and a queue scoreboard checks each completed transaction.
module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        cpu_as_;
  logic        cpu_rw;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        busy;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];

  bus_master_if #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .cpu_as_(cpu_as_), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .busy(busy),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; cpu_as_ = 1'b1; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_wr_data = '0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus_req_, bus_as_, busy, bus_rw} !== 4'b1101 || bus_addr !== 30'h0 ||
        bus_wr_data !== 32'h0 || cpu_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: req_/as_/busy/rw=%b%b%b%b addr=%h wd=%h rd=%h, required 1101 0 0 0",
               bus_req_, bus_as_, busy, bus_rw, bus_addr, bus_wr_data, cpu_rd_data);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  // Drives one transaction. gnt_cyc: cycle (>=1) in which grant goes low;
  // waits: ready-high cycles after the strobe; stall_cyc: extra stall cycles.
  task automatic do_txn(input logic rw, input logic [29:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_cyc, input int waits,
                        input int stall_cyc, input logic fl);
    txn_t t;
    txn_t e;
    next_cycle();
    cpu_as_ = 1'b0; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wdata; flush = 1'b0;
    bus_grnt_ = (gnt_cyc <= 1) ? 1'b0 : 1'b1;
    t = '{rw: rw, addr: addr, wdata: wdata, rdata: rdata};
    sb.push_back(t);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus_req_ !== 1'b1) begin
      failures++;
      $display("FAIL launch: busy=%b req_=%b, required busy=1 req_=1", busy, bus_req_);
    end
    for (int k = 1; k <= gnt_cyc; k++) begin
      next_cycle();
      cpu_as_ = 1'b1; cpu_rw = ~rw; cpu_addr = ~addr; cpu_wr_data = ~wdata;
      if (k == gnt_cyc) bus_grnt_ = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_req_, bus_as_, busy} !== 3'b011 || bus_addr !== addr || bus_rw !== rw ||
          bus_wr_data !== wdata) begin
        failures++;
        $display("FAIL req_phase cyc%0d: req_/as_/busy=%b%b%b addr=%h rw=%b wd=%h, required 011 %h %b %h",
                 k, bus_req_, bus_as_, busy, bus_addr, bus_rw, bus_wr_data, addr, rw, wdata);
      end
    end
    next_cycle();
    flush = fl;
    @(negedge clk);
    checks++;
    if ({bus_req_, bus_as_, busy} !== 3'b001) begin
      failures++;
      $display("FAIL strobe: req_/as_/busy=%b%b%b, required 001", bus_req_, bus_as_, busy);
    end
    for (int w = 0; w < waits; w++) begin
      next_cycle();
      bus_rdy_ = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_req_, bus_as_, busy} !== 3'b011 || bus_addr !== addr) begin
        failures++;
        $display("FAIL wait_state %0d: req_/as_/busy=%b%b%b addr=%h, required 011 %h",
                 w, bus_req_, bus_as_, busy, bus_addr, addr);
      end
    end
    next_cycle();
    bus_rdy_ = 1'b0; bus_rd_data = rdata; stall = (stall_cyc > 0);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (busy !== 1'b0 || bus_req_ !== 1'b0 || cpu_rd_data !== e.rdata || bus_addr !== e.addr ||
        bus_rw !== e.rw || bus_wr_data !== e.wdata) begin
      failures++;
      $display("FAIL complete: busy=%b req_=%b rd=%h addr=%h rw=%b wd=%h, required 0 0 %h %h %b %h",
               busy, bus_req_, cpu_rd_data, bus_addr, bus_rw, bus_wr_data,
               e.rdata, e.addr, e.rw, e.wdata);
    end
    $display("txn rw=%b addr=%h wdata=%h rdata=%h grant_cyc=%0d waits=%0d stall=%0d",
             rw, addr, wdata, cpu_rd_data, gnt_cyc, waits, stall_cyc);
    next_cycle();
    bus_rdy_ = 1'b1; bus_rd_data = ~rdata; flush = 1'b0;
    if (stall_cyc > 0) begin
      for (int s = 0; s < stall_cyc; s++) begin
        cpu_as_ = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_req_, bus_as_, busy} !== 3'b110 || cpu_rd_data !== rdata || bus_addr !== 30'h0) begin
          failures++;
          $display("FAIL stall_hold %0d: req_/as_/busy=%b%b%b rd=%h addr=%h, required 110 %h 0",
                   s, bus_req_, bus_as_, busy, cpu_rd_data, bus_addr, rdata);
        end
        next_cycle();
      end
      cpu_as_ = 1'b1; stall = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cpu_rd_data !== rdata || bus_req_ !== 1'b1) begin
        failures++;
        $display("FAIL stall_release: busy=%b rd=%h req_=%b, required 0 %h 1",
                 busy, cpu_rd_data, bus_req_, rdata);
      end
      next_cycle();
    end
    cpu_as_ = 1'b1; bus_grnt_ = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_req_, bus_as_, busy, bus_rw} !== 4'b1101 || bus_addr !== 30'h0 ||
        bus_wr_data !== 32'h0 || cpu_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL idle_after: req_/as_/busy/rw=%b%b%b%b addr=%h wd=%h rd=%h, required 1101 0 0 0",
               bus_req_, bus_as_, busy, bus_rw, bus_addr, bus_wr_data, cpu_rd_data);
    end
  endtask

  task automatic test_read_immediate();
    do_txn(1'b1, 30'h100, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 1, 0, 0, 1'b0);
  endtask

  task automatic test_write_delayed_grant();
    do_txn(1'b0, 30'h2A, 32'h1234_5678, 32'h5555_AAAA, 4, 0, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    do_txn(1'b1, 30'h3FF0_0001, 32'h0, 32'hA5A5_0F0F, 1, 5, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_txn(1'b1, 30'h44, 32'h0, 32'hCAFE_F00D, 2, 1, 3, 1'b0);
  endtask

  task automatic test_flush();
    next_cycle();
    flush = 1'b1; cpu_as_ = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: busy=%b, required 0", busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus_req_ !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_blocks: req_=%b busy=%b, required 1 0", bus_req_, busy);
    end
    next_cycle();
    flush = 1'b0; cpu_as_ = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_req_ !== 1'b1) begin
      failures++;
      $display("FAIL flush_no_launch: req_=%b, required 1", bus_req_);
    end
    do_txn(1'b0, 30'h77, 32'hF1F2_F3F4, 32'h0101_0202, 1, 2, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 30'h10, 32'h0, 32'h1111_2222, 1, 0, 0, 1'b0);
    do_txn(1'b0, 30'h11, 32'h3333_4444, 32'h0, 1, 0, 0, 1'b0);
    do_txn(1'b1, 30'h12, 32'h0, 32'h5555_6666, 3, 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    next_cycle();
    cpu_as_ = 1'b0; cpu_rw = 1'b0; cpu_addr = 30'h1234; cpu_wr_data = 32'h9999_8888;
    bus_grnt_ = 1'b0;
    next_cycle();
    cpu_as_ = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus_req_ !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync: busy=%b req_=%b, required 1 0", busy, bus_req_);
    end
    next_cycle();
    reset = 1'b0; bus_grnt_ = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_req_, bus_as_, busy, bus_rw} !== 4'b1101 || bus_addr !== 30'h0 ||
        bus_wr_data !== 32'h0 || cpu_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: req_/as_/busy/rw=%b%b%b%b addr=%h wd=%h rd=%h, required 1101 0 0 0",
               bus_req_, bus_as_, busy, bus_rw, bus_addr, bus_wr_data, cpu_rd_data);
    end
    do_txn(1'b1, 30'h55, 32'h0, 32'h7777_0000, 1, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read_immediate();
    test_write_delayed_grant();
    test_wait_states();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
